// File: rtl/opb_master_seq.sv
// OPB initiator: turns host register commands into OPB write/read/poll cycles
// and returns one response per command over a valid/ready handshake.
module opb_master_seq #(
  parameter int NUM_SLAVES = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int RD_WAIT    = 1,
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RSTb,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic [SEL_WIDTH-1:0]  CMD_SEL,
  input  logic [3:0]            CMD_ADDR,
  input  logic [31:0]           CMD_WDATA,
  input  logic [31:0]           CMD_MASK,
  input  logic                  CMD_ABORT,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [31:0]           RSP_DATA,
  output logic [1:0]            RSP_STATUS,
  output logic [NUM_SLAVES-1:0] OPB_CS,
  output logic [3:0]            OPB_ADDR,
  output logic [31:0]           OPB_DI,
  output logic                  OPB_WE,
  output logic                  OPB_RE,
  input  logic [31:0]           OPB_DO
);

  localparam int AW = $clog2(POLL_LIMIT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WRITE, S_READ, S_POLL_RD, S_POLL_WAIT, S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [3:0]             addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            mask_q, mask_d;
  logic [3:0]             wait_q, wait_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [AW-1:0]          att_q, att_d;
  logic [31:0]            last_q, last_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic [1:0]             rsp_status_q, rsp_status_d;

  logic          sample_done;
  logic          match;
  logic [AW-1:0] att_inc;
  logic          bus_active;

  assign sample_done = (wait_q == 4'(RD_WAIT));
  assign match       = ((OPB_DO & mask_q) == (wdata_q & mask_q));
  assign att_inc     = att_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    wait_d       = wait_q;
    gap_d        = gap_q;
    att_d        = att_q;
    last_d       = last_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          op_d    = CMD_OP;
          sel_d   = CMD_SEL;
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          mask_d  = CMD_MASK;
          att_d   = '0;
          last_d  = '0;
          state_d = S_DECODE;
        end
      end
      // One setup cycle between accept and the first bus strobe.
      S_DECODE: begin
        wait_d = '0;
        if (op_q == 2'b11 || int'(sel_q) >= NUM_SLAVES) begin
          rsp_data_d   = '0;
          rsp_status_d = 2'b10;
          state_d      = S_RESP;
        end else if (op_q == 2'b00) begin
          state_d = S_WRITE;
        end else if (op_q == 2'b01) begin
          state_d = S_READ;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_WRITE: begin
        rsp_data_d   = '0;
        rsp_status_d = 2'b00;
        state_d      = S_RESP;
      end
      S_READ: begin
        if (sample_done) begin
          rsp_data_d   = OPB_DO;
          rsp_status_d = 2'b00;
          state_d      = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_POLL_RD: begin
        if (CMD_ABORT) begin
          rsp_data_d   = last_q;
          rsp_status_d = 2'b11;
          state_d      = S_RESP;
        end else if (sample_done) begin
          att_d  = att_inc;
          last_d = OPB_DO;
          wait_d = '0;
          if (match) begin
            rsp_data_d   = OPB_DO;
            rsp_status_d = 2'b00;
            state_d      = S_RESP;
          end else if (att_inc == AW'(POLL_LIMIT)) begin
            rsp_data_d   = OPB_DO;
            rsp_status_d = 2'b01;
            state_d      = S_RESP;
          end else begin
            gap_d   = '0;
            state_d = S_POLL_WAIT;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_POLL_WAIT: begin
        if (CMD_ABORT) begin
          rsp_data_d   = last_q;
          rsp_status_d = 2'b11;
          state_d      = S_RESP;
        end else if (gap_q == GW'(POLL_GAP - 1)) begin
          wait_d  = '0;
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RESP: begin
        if (RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RSTb) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      wait_q       <= '0;
      gap_q        <= '0;
      att_q        <= '0;
      last_q       <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      wait_q       <= wait_d;
      gap_q        <= gap_d;
      att_q        <= att_d;
      last_q       <= last_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Bus outputs decode straight from state so CS can never outlive its strobe.
  assign OPB_WE     = (state_q == S_WRITE);
  assign OPB_RE     = (state_q == S_READ) || (state_q == S_POLL_RD);
  assign bus_active = OPB_WE || OPB_RE;
  assign OPB_CS     = bus_active ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign OPB_ADDR   = bus_active ? addr_q : '0;
  assign OPB_DI     = bus_active ? wdata_q : '0;

  assign CMD_READY  = (state_q == S_IDLE) && OPB_RSTb;
  assign RSP_VALID  = (state_q == S_RESP);
  assign RSP_DATA   = rsp_data_q;
  assign RSP_STATUS = rsp_status_q;

endmodule

// File: tb/tb_opb_master_seq.sv
// Directed bench for opb_master_seq: write, read, poll match/timeout/abort,
// bad commands, response back-pressure and reset mid-read.
module tb_opb_master_seq;
  localparam int NS = 8;
  localparam int SW = 4;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rstb;
  logic          cmd_valid, cmd_ready, cmd_abort;
  logic [1:0]    cmd_op;
  logic [SW-1:0] cmd_sel;
  logic [3:0]    cmd_addr;
  logic [31:0]   cmd_wdata, cmd_mask;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_status;
  logic [NS-1:0] opb_cs;
  logic [3:0]    opb_addr;
  logic [31:0]   opb_di;
  logic          opb_we, opb_re;
  wire  [31:0]   opb_do;

  always #5 clk = ~clk;

  opb_master_seq #(
    .NUM_SLAVES(NS), .SEL_WIDTH(SW), .RD_WAIT(1), .POLL_GAP(16), .POLL_LIMIT(PL)
  ) dut (
    .OPB_CLK(clk), .OPB_RSTb(rstb),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_SEL(cmd_sel), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
    .CMD_MASK(cmd_mask), .CMD_ABORT(cmd_abort),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .RSP_STATUS(rsp_status),
    .OPB_CS(opb_cs), .OPB_ADDR(opb_addr), .OPB_DI(opb_di),
    .OPB_WE(opb_we), .OPB_RE(opb_re), .OPB_DO(opb_do)
  );

  // Peripheral model: 1 fixed read value, 2 poll turning true on 3rd read, 3 never true.
  int          mode = 0;
  int          poll_thresh = 0;
  int          re_pulses = 0;
  logic [31:0] do_val;

  always_comb begin
    do_val = 32'h0;
    case (mode)
      1: do_val = opb_cs[0] ? 32'h0000_0535 : 32'h0;
      2: do_val = (re_pulses >= poll_thresh) ? 32'h0000_0102 : 32'h0000_0100;
      3: do_val = 32'h0000_00F0;
      default: do_val = 32'h0;
    endcase
  end
  assign opb_do = opb_re ? do_val : 32'bz;

  always @(posedge opb_re) re_pulses++;

  int we_cyc = 0, re_cyc = 0, cs_cyc = 0, rsp_cyc = 0, viol = 0;
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (opb_we && opb_re) viol++;
      if ((opb_we || opb_re) ? !$onehot(opb_cs) : (opb_cs != '0)) viol++;
      we_cyc  += int'(opb_we);
      re_cyc  += int'(opb_re);
      cs_cyc  += int'(opb_cs != '0);
      rsp_cyc += int'(rsp_valid);
    end
  end

  int total = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [SW-1:0] sel, input logic [3:0] addr,
                      input logic [31:0] wd, input logic [31:0] mk);
    cmd_op = op; cmd_sel = sel; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, wb, rb, cb, pb, sb;
    rstb = 1'b0; cmd_valid = 1'b0; cmd_abort = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_sel = '0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_cs", opb_cs, 0);
    chk("rst_we_re", {opb_we, opb_re}, 0);
    chk("rst_addr_di", opb_addr | opb_di, 0);
    rstb = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    // Write SEL=2 ADDR=8
    #1 wb = we_cyc;
    send(2'b00, 2, 4'd8, 32'h258, 32'h0);
    chk("wr_c0_we", opb_we, 0);
    @(negedge clk);
    chk("wr_c1_we", opb_we, 1);
    chk("wr_c1_cs", opb_cs, 32'h4);
    chk("wr_c1_addr", opb_addr, 8);
    chk("wr_c1_di", opb_di, 32'h258);
    chk("wr_c1_rspv", rsp_valid, 0);
    @(negedge clk);
    chk("wr_c2_we", opb_we, 0);
    chk("wr_c2_rspv", rsp_valid, 1);
    chk("wr_data", rsp_data, 0);
    chk("wr_status", rsp_status, 0);
    consume();
    chk("wr_done_rspv", rsp_valid, 0);
    chk("wr_done_ready", cmd_ready, 1);
    #1 chk("wr_we_cycles", we_cyc - wb, 1);

    // Read SEL=0 ADDR=2
    mode = 1;
    rb = re_cyc;
    send(2'b01, 0, 4'd2, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_c1_re", opb_re, 1);
    chk("rd_c1_cs", opb_cs, 32'h1);
    chk("rd_c1_addr", opb_addr, 2);
    @(negedge clk);
    chk("rd_c2_re", opb_re, 1);
    chk("rd_c2_rspv", rsp_valid, 0);
    @(negedge clk);
    chk("rd_c3_re", opb_re, 0);
    chk("rd_c3_rspv", rsp_valid, 1);
    chk("rd_data", rsp_data, 32'h535);
    chk("rd_status", rsp_status, 0);
    consume();
    #1 chk("rd_re_cycles", re_cyc - rb, 2);

    // Poll matching on the third read
    mode = 2;
    rb = re_cyc; pb = re_pulses;
    poll_thresh = pb + 3;
    send(2'b10, 1, 4'd5, 32'h2, 32'h2);
    wait_rsp(200, c);
    chk("poll_latency", c, 39);
    chk("poll_status", rsp_status, 0);
    chk("poll_data", rsp_data, 32'h102);
    chk("poll_reads", re_pulses - pb, 3);
    consume();
    #1 chk("poll_re_cycles", re_cyc - rb, 6);

    // Poll timeout after POLL_LIMIT reads
    mode = 3;
    pb = re_pulses;
    send(2'b10, 3, 4'd4, 32'h1, 32'h1);
    wait_rsp(300, c);
    chk("tmo_latency", c, 57);
    chk("tmo_status", rsp_status, 1);
    chk("tmo_data", rsp_data, 32'hF0);
    chk("tmo_reads", re_pulses - pb, PL);
    consume();

    // Abort during POLL_WAIT
    pb = re_pulses;
    send(2'b10, 3, 4'd4, 32'h1, 32'h1);
    repeat (5) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("abort_rspv", rsp_valid, 1);
    chk("abort_status", rsp_status, 3);
    chk("abort_data", rsp_data, 32'hF0);
    repeat (30) @(negedge clk);
    chk("abort_reads", re_pulses - pb, 1);
    consume();

    // Bad commands: illegal op and out-of-range select
    #1 begin wb = we_cyc; rb = re_cyc; cb = cs_cyc; end
    send(2'b11, 1, 4'd1, 32'h0, 32'h0);
    wait_rsp(20, c);
    chk("bad_op_rspv", rsp_valid, 1);
    chk("bad_op_status", rsp_status, 2);
    consume();
    send(2'b00, 9, 4'd1, 32'hAA, 32'h0);
    wait_rsp(20, c);
    chk("bad_sel_rspv", rsp_valid, 1);
    chk("bad_sel_status", rsp_status, 2);
    chk("bad_sel_data", rsp_data, 0);
    consume();
    #1 begin
      chk("bad_we_cycles", we_cyc - wb, 0);
      chk("bad_re_cycles", re_cyc - rb, 0);
      chk("bad_cs_cycles", cs_cyc - cb, 0);
    end

    // Response back-pressure with a competing command waiting
    mode = 1;
    send(2'b01, 0, 4'd2, 32'h0, 32'h0);
    wait_rsp(20, c);
    #1 wb = we_cyc;
    cmd_op = 2'b00; cmd_sel = 3; cmd_addr = 4'd7; cmd_wdata = 32'h55;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_rspv", rsp_valid, 1);
      chk("bp_data", rsp_data, 32'h535);
      chk("bp_status", rsp_status, 0);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    consume();
    chk("bp_done_rspv", rsp_valid, 0);
    #1 chk("bp_no_write", we_cyc - wb, 0);

    // Reset in the middle of a read
    sb = rsp_cyc;
    send(2'b01, 0, 4'd2, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstrd_re_before", opb_re, 1);
    rstb = 1'b0;
    @(negedge clk);
    chk("rstrd_re_after", opb_re, 0);
    chk("rstrd_cs_after", opb_cs, 0);
    chk("rstrd_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk("rstrd_no_rsp", rsp_cyc - sb, 0);
    chk("rstrd_ready", cmd_ready, 1);

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
